// File: rtl/pc_unit.sv
// Registered program counter for the MiniSys-1A fetch stage: prioritised
// next-PC selection, redirect flush pulse and sticky misalignment flag.
// Optional macro PC_EPC_EN: keep an internal EPC register for eret returns.
module pc_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned STEP       = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exception,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc_in,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             pc_valid,
    output logic             flush,
    output logic             addr_err
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] RST_VAL    = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] EXC_VAL    = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] STEP_VAL   = WIDTH'(STEP);
    // Low address bits that must be zero for a step-aligned target; zero when STEP=1.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             flush_q, flush_d;
    logic             addr_err_q, addr_err_d;
    logic [WIDTH-1:0] ret_pc;

    function automatic logic misaligned(input logic [WIDTH-1:0] target);
        return (target & ALIGN_MASK) != '0;
    endfunction

`ifdef PC_EPC_EN
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             unused_epc_in;

    assign unused_epc_in = ^epc_in;
    assign ret_pc        = epc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_q <= RST_VAL;
        end else begin
            epc_q <= epc_d;
        end
    end

    always_comb begin
        epc_d = epc_q;
        if (state_q == RUN && exception) begin
            epc_d = pc_q;
        end
    end
`else
    assign ret_pc = epc_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RST_VAL;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= flush_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        flush_d    = 1'b0;
        addr_err_d = addr_err_q;
        if (state_q == BOOT) begin
            // Controls are ignored for the single boot edge after reset.
            state_d    = RUN;
            pc_valid_d = 1'b1;
        end else if (exception) begin
            pc_d    = EXC_VAL;
            flush_d = 1'b1;
        end else if (eret) begin
            pc_d    = ret_pc;
            flush_d = 1'b1;
            if (misaligned(ret_pc)) addr_err_d = 1'b1;
        end else if (jump) begin
            pc_d    = jump_target;
            flush_d = 1'b1;
            if (misaligned(jump_target)) addr_err_d = 1'b1;
        end else if (branch_taken) begin
            pc_d    = branch_target;
            flush_d = 1'b1;
            if (misaligned(branch_target)) addr_err_d = 1'b1;
        end else if (!stall) begin
            pc_d = pc_q + STEP_VAL;
        end
    end

    assign pc           = pc_q;
    assign pc_plus_step = pc_q + STEP_VAL;
    assign pc_valid     = pc_valid_q;
    assign flush        = flush_q;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model pushes the expected
// post-edge state each cycle; each test pops and compares it against the DUT.
module tb_pc_unit;

`ifdef PC_EPC_EN
    localparam bit EPC_EN = 1'b1;
`else
    localparam bit EPC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump, exception, eret;
    logic [31:0] branch_target, jump_target, epc_in;
    logic [31:0] pc, pc_plus_step;
    logic        pc_valid, flush, addr_err;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_pc, m_epc;
    logic        m_valid, m_flush, m_err, m_run;

    pc_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exception    (exception),
        .eret         (eret),
        .epc_in       (epc_in),
        .pc           (pc),
        .pc_plus_step (pc_plus_step),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_ctrl();
        stall = 0; branch_taken = 0; jump = 0; exception = 0; eret = 0;
        branch_target = '0; jump_target = '0; epc_in = '0;
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_valid = 0; m_flush = 0; m_err = 0; m_run = 0;
        q.delete();
    endtask

    // Advance one clock: predict the post-edge state, push it, then settle.
    task automatic cycle();
        exp_t        e;
        logic [31:0] tgt;
        if (!m_run) begin
            m_run = 1; m_valid = 1; m_flush = 0;
        end else if (exception) begin
            m_epc = m_pc; m_pc = 32'h4; m_flush = 1;
        end else if (eret) begin
            tgt = EPC_EN ? m_epc : epc_in;
            if (tgt[1:0] != 2'b00) m_err = 1;
            m_pc = tgt; m_flush = 1;
        end else if (jump) begin
            if (jump_target[1:0] != 2'b00) m_err = 1;
            m_pc = jump_target; m_flush = 1;
        end else if (branch_taken) begin
            if (branch_target[1:0] != 2'b00) m_err = 1;
            m_pc = branch_target; m_flush = 1;
        end else if (stall) begin
            m_flush = 0;
        end else begin
            m_pc = m_pc + 32'd4; m_flush = 0;
        end
        e.pc = m_pc; e.valid = m_valid; e.flush = m_flush; e.err = m_err;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        clear_ctrl();
        rst_n = 0;
        model_reset();
        #12;
        checks++;
        if (pc !== 32'h0 || pc_valid !== 1'b0 || flush !== 1'b0 || addr_err !== 1'b0
            || pc_plus_step !== 32'h4) begin
            errors++;
            $display("FAIL reset_state pc=%h valid=%b flush=%b err=%b pps=%h required pc=0 valid=0 flush=0 err=0 pps=4",
                     pc, pc_valid, flush, addr_err, pc_plus_step);
        end
        #6 rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            e = q.pop_front();
            checks++;
            if (pc !== e.pc || pc_valid !== e.valid || flush !== e.flush || addr_err !== e.err
                || pc_plus_step !== e.pc + 32'd4) begin
                errors++;
                $display("FAIL boot_seq[%0d] pc=%h valid=%b flush=%b err=%b pps=%h required pc=%h valid=%b flush=%b err=%b",
                         i, pc, pc_valid, flush, addr_err, pc_plus_step, e.pc, e.valid, e.flush, e.err);
            end
        end
        checks++;
        if (pc !== 32'h10) begin
            errors++;
            $display("FAIL boot_end pc=%h required 10", pc);
        end
    endtask

    task automatic test_stall_branch();
        exp_t e;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            e = q.pop_front();
            checks++;
            if (pc !== e.pc || pc !== 32'h10 || flush !== e.flush) begin
                errors++;
                $display("FAIL stall_hold[%0d] pc=%h flush=%b required pc=%h flush=%b", i, pc, flush, e.pc, e.flush);
            end
        end
        branch_taken = 1; branch_target = 32'h40;
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || pc !== 32'h40 || flush !== 1'b1) begin
            errors++;
            $display("FAIL stall_branch pc=%h flush=%b required pc=%h flush=1", pc, flush, e.pc);
        end
        clear_ctrl();
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || flush !== e.flush || pc !== 32'h44 || flush !== 1'b0) begin
            errors++;
            $display("FAIL flush_pulse_end pc=%h flush=%b required pc=%h flush=%b", pc, flush, e.pc, e.flush);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        exception = 1; jump = 1; jump_target = 32'h80; branch_taken = 1; branch_target = 32'h40;
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || pc !== 32'h4 || flush !== 1'b1) begin
            errors++;
            $display("FAIL priority_exc pc=%h flush=%b required pc=%h flush=1", pc, flush, e.pc);
        end
        exception = 0;
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || pc !== 32'h80 || flush !== 1'b1) begin
            errors++;
            $display("FAIL priority_jump pc=%h flush=%b required pc=%h flush=1", pc, flush, e.pc);
        end
        clear_ctrl();
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] tg [3];
        tg[0] = 32'h100; tg[1] = 32'h200; tg[2] = 32'h300;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                jump = 0; branch_taken = 1; branch_target = tg[i];
            end else begin
                branch_taken = 0; jump = 1; jump_target = tg[i];
            end
            cycle();
            e = q.pop_front();
            checks++;
            if (pc !== e.pc || flush !== e.flush || flush !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d] pc=%h flush=%b required pc=%h flush=1", i, pc, flush, e.pc);
            end
        end
        clear_ctrl();
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || flush !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end pc=%h flush=%b required pc=%h flush=0", pc, flush, e.pc);
        end
    endtask

    task automatic test_wrap_align();
        exp_t e;
        jump = 1; jump_target = 32'hFFFF_FFFC;
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_jump pc=%h err=%b required pc=%h err=0", pc, addr_err, e.pc);
        end
        clear_ctrl();
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || pc !== 32'h0 || addr_err !== 1'b0 || pc_plus_step !== 32'h4) begin
            errors++;
            $display("FAIL wrap_zero pc=%h err=%b pps=%h required pc=0 err=0 pps=4", pc, addr_err, pc_plus_step);
        end
        branch_taken = 1; branch_target = 32'h0000_0102;
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || pc !== 32'h102 || addr_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_load pc=%h err=%b required pc=102 err=1", pc, addr_err);
        end
        clear_ctrl();
        for (int i = 0; i < 10; i++) begin
            cycle();
            e = q.pop_front();
            checks++;
            if (pc !== e.pc || addr_err !== e.err || addr_err !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky[%0d] pc=%h err=%b required pc=%h err=1", i, pc, addr_err, e.pc);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        jump = 1; jump_target = 32'h30;
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || pc !== 32'h30 || flush !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset pc=%h flush=%b required pc=30 flush=1", pc, flush);
        end
        clear_ctrl();
        #3 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (pc !== 32'h0 || flush !== 1'b0 || pc_valid !== 1'b0 || addr_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pc=%h flush=%b valid=%b err=%b required pc=0 flush=0 valid=0 err=0",
                     pc, flush, pc_valid, addr_err);
        end
        #2 rst_n = 1;
    endtask

    task automatic test_epc();
        exp_t e;
        // Boot edge then nine steps reach 0x24.
        for (int i = 0; i < 10; i++) begin
            cycle();
            e = q.pop_front();
            checks++;
            if (pc !== e.pc || pc_valid !== e.valid || flush !== e.flush) begin
                errors++;
                $display("FAIL epc_walk[%0d] pc=%h valid=%b flush=%b required pc=%h valid=%b flush=%b",
                         i, pc, pc_valid, flush, e.pc, e.valid, e.flush);
            end
        end
        exception = 1;
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || pc !== 32'h4 || flush !== 1'b1) begin
            errors++;
            $display("FAIL epc_exc pc=%h flush=%b required pc=4 flush=1", pc, flush);
        end
        exception = 0; eret = 1; epc_in = 32'h99;
        cycle();
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || pc !== (EPC_EN ? 32'h24 : 32'h99) || flush !== 1'b1 || addr_err !== e.err) begin
            errors++;
            $display("FAIL eret_return pc=%h flush=%b err=%b required pc=%h flush=1 err=%b",
                     pc, flush, addr_err, e.pc, e.err);
        end
        clear_ctrl();
    endtask

    initial begin
        test_reset();
        test_stall_branch();
        test_priority();
        test_back_to_back();
        test_wrap_align();
        test_async_reset();
        test_epc();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter block for the MiniSys-1A fetch stage.
- Generalises the PC+4 adder into a registered PC with the following features:
  - configurable width, step and reset/exception vectors;
  - prioritised next-PC selection (exception, return-from-exception, jump, branch, stall, sequential);
  - a one-cycle fetch-flush pulse on redirects;
  - a misalignment check.
- Feeds instruction-memory address and the `pc_plus_step` link value to the ID/EX stages.

Parameters:
- WIDTH, 32, PC and target width in bits.
- STEP, 4, sequential increment in bytes; power of two, at least 1.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (truncated to WIDTH).
- EXC_VECTOR, 32'h0000_0004, exception handler entry address (truncated to WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold the PC (pipeline hazard).
- branch_taken  in  1  load `branch_target`.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  load `jump_target`.
- jump_target  in  WIDTH  jump destination.
- exception  in  1  load EXC_VECTOR.
- eret  in  1  return from exception.
- epc_in  in  WIDTH  return address (used when PC_EPC_EN is undefined).
- pc  out  WIDTH  current fetch address.
- pc_plus_step  out  WIDTH  pc + STEP, modulo 2^WIDTH, combinational from `pc`.
- pc_valid  out  1  fetch address is valid.
- flush  out  1  one-cycle pulse: discard the instruction fetched at the old `pc`.
- addr_err  out  1  sticky misaligned-target flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, pc_valid=0, flush=0, addr_err=0, state=BOOT.
- States: BOOT, RUN.
- BOOT:
  - Lasts exactly one clk edge after rst_n rises.
  - pc stays RESET_PC; then pc_valid goes to 1 and state goes to RUN.
  - All control inputs are ignored in BOOT.
- RUN: next-PC priority on each rising edge, highest first.
  1. exception: pc←EXC_VECTOR, flush←1.
  2. eret: pc←return address, flush←1.
  3. jump: pc←jump_target, flush←1.
  4. branch_taken: pc←branch_target, flush←1.
  5. stall: pc held, flush←0.
  6. Otherwise: pc←pc+STEP (wraps at 2^WIDTH with no flag), flush←0.
- Stall handling:
  - A redirect (items 1–4) overrides stall; it is never lost.
  - flush is registered; it is high for exactly the cycle after a redirect edge.
  - Back-to-back redirects keep flush high.
- Alignment check:
  - On a jump/branch/eret load, if target[log2(STEP)-1:0] != 0, addr_err←1.
  - addr_err stays 1 until reset.
  - The target is still loaded as given, with no masking.
  - Not checked when STEP=1.
- Latency:
  - `pc` updates 1 clk after the control is sampled.
  - `pc_plus_step` is combinational from `pc` (0 latency).
- Reset asserted mid-operation: immediate return to reset values regardless of clk; returns to BOOT.
- Width rule: all arithmetic is WIDTH bits unsigned; the carry out is discarded.

Optional Feature:
- Macro: PC_EPC_EN.
- Defined:
  - An internal WIDTH-bit EPC register, reset to RESET_PC.
  - On an exception edge, EPC←current pc.
  - eret returns to the EPC register; epc_in is ignored.
  - Exception and eret in the same cycle: exception wins, EPC is updated, and eret is dropped.
- Undefined: no EPC register; eret returns to epc_in.

Test Plan:
- Reset/boot, defaults: rst_n low then high, no controls.
  → pc=0x0 for 2 edges with pc_valid 0→1, then 0x4, 0x8, 0xC; pc_plus_step=pc+4.
- Stall vs branch: at pc=0x10, stall=1 for 3 cycles.
  → pc holds 0x10.
  - Then stall=1 with branch_taken=1, branch_target=0x40 → pc=0x40, flush=1 for one cycle.
- Priority: exception=1, jump=1 (jump_target=0x80), branch_taken=1 in the same cycle.
  → pc=EXC_VECTOR (0x4), flush=1.
- Wrap and alignment: WIDTH=32, jump to 0xFFFF_FFFC.
  → next pc=0x0, addr_err stays 0.
  - Then branch to 0x0000_0102 → pc=0x102, addr_err=1 and sticky through 10 further cycles.
- EPC round trip, PC_EPC_EN defined: exception at pc=0x24.
  → pc=0x4.
  - Then eret with epc_in=0x99 → pc=0x24.
  - Repeat with PC_EPC_EN undefined → pc=0x99.
- Async reset mid-run: pull rst_n low between clock edges at pc=0x30.
  → pc=0x0 and flush=0 immediately, without waiting for a clk edge.
